// File: rtl/gray_rx_checker.sv
// Gray-coded count receiver: decodes G to binary, checks each sample is a legal +1 step,
// tracks lock. Define GRAY_RX_ERRCNT_EN to implement the saturating err_cnt (tied to 0 otherwise).
module gray_rx_checker #(
    parameter int W      = 4,
    parameter int LOCK_N = 2,
    parameter int ERRW   = 8
) (
    input  logic            clk,
    input  logic            r,
    input  logic            ce,
    input  logic [W-1:0]    G,
    output logic [W-1:0]    B,
    output logic            valid,
    output logic            step_ok,
    output logic            wrap,
    output logic            err,
    output logic            locked,
    output logic [ERRW-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [3:0]   LOCK_C = 4'(LOCK_N);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_prev;
    logic [3:0]     r_gcnt, w_gcnt_nxt;
    logic [W-1:0]   w_bin;
    logic           w_good, w_bad;
    logic           r_valid, r_step_ok, r_wrap, r_err, r_locked;

    // Binary bit i is the XOR of all Gray bits at or above position i.
    for (genvar i = 0; i < W; i++) begin : g_dec
        assign w_bin[i] = ^(G >> i);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (ce) begin
            case (r_state)
                IDLE: w_state_nxt = ACQ;
                default: begin
                    if (w_bin == r_prev + ONE) begin
                        w_good = 1'b1;
                        if (r_gcnt != LOCK_C)
                            w_gcnt_nxt = r_gcnt + 4'd1;
                        if (w_gcnt_nxt == LOCK_C)
                            w_state_nxt = LOCK;
                    end else if (w_bin != r_prev) begin
                        w_bad       = 1'b1;
                        w_gcnt_nxt  = 4'd0;
                        w_state_nxt = ACQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_state   <= IDLE;
            r_gcnt    <= 4'd0;
            r_prev    <= '0;
            r_valid   <= 1'b0;
            r_step_ok <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_valid   <= ce;
            r_step_ok <= w_good;
            r_wrap    <= w_good && (r_prev == '1);
            r_err     <= w_bad;
            r_locked  <= (w_state_nxt == LOCK);
            if (ce)
                r_prev <= w_bin;
        end
    end

    // The held reference sample doubles as the registered binary output.
    assign B       = r_prev;
    assign valid   = r_valid;
    assign step_ok = r_step_ok;
    assign wrap    = r_wrap;
    assign err     = r_err;
    assign locked  = r_locked;

`ifdef GRAY_RX_ERRCNT_EN
    logic [ERRW-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (r)
            r_err_cnt <= '0;
        else if (w_bad && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERRW'(1);
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: directed vector table, then randomized traffic against a behavioural model.
module tb_gray_rx_checker;

    localparam int W      = 4;
    localparam int LOCK_N = 2;
    localparam int ERRW   = 2;
    localparam int MODN   = 1 << W;
`ifdef GRAY_RX_ERRCNT_EN
    localparam int EC_CAP = (1 << ERRW) - 1;
`else
    localparam int EC_CAP = 0;
`endif

    logic            clk = 1'b0;
    logic            r, ce;
    logic [W-1:0]    G;
    logic [W-1:0]    B;
    logic            valid, step_ok, wrap, err, locked;
    logic [ERRW-1:0] err_cnt;

    gray_rx_checker #(.W(W), .LOCK_N(LOCK_N), .ERRW(ERRW)) dut (
        .clk(clk), .r(r), .ce(ce), .G(G),
        .B(B), .valid(valid), .step_ok(step_ok), .wrap(wrap),
        .err(err), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rr, cc;
        int   g, b, v, s, w, e, l, ec;
    } vec_t;
    vec_t vecs[$];

    // Behavioural model state
    int m_ref = 0, m_prev = 0, m_run = 0, m_lk = 0, m_ec = 0;
    int m_b = 0, m_v = 0, m_s = 0, m_w = 0, m_e = 0;

    function automatic int gray_to_bin(input int g);
        for (int k = 0; k < MODN; k++)
            if ((k ^ (k >> 1)) == g) return k;
        return -1;
    endfunction

    task automatic model(input logic rr, input logic cc, input int g);
        int b;
        if (rr) begin
            m_ref = 0; m_prev = 0; m_run = 0; m_lk = 0; m_ec = 0;
            m_b = 0; m_v = 0; m_s = 0; m_w = 0; m_e = 0;
        end else if (!cc) begin
            m_v = 0; m_s = 0; m_w = 0; m_e = 0;
        end else begin
            b = gray_to_bin(g);
            m_v = 1; m_s = 0; m_w = 0; m_e = 0;
            if (m_ref == 0) begin
                m_ref = 1;
            end else if (b == (m_prev + 1) % MODN) begin
                m_s = 1;
                m_w = (m_prev == MODN - 1) ? 1 : 0;
                if (m_run < LOCK_N) m_run++;
                if (m_run == LOCK_N) m_lk = 1;
            end else if (b != m_prev) begin
                m_e = 1; m_run = 0; m_lk = 0;
                if (m_ec < EC_CAP) m_ec++;
            end
            m_prev = b;
            m_b = b;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rr, input logic cc, input int g);
        r  = rr;
        ce = cc;
        G  = W'(g);
        @(posedge clk);
        #1;
        model(rr, cc, g);
    endtask

    task automatic addv(input logic rr, input logic cc, input int g, input int b, input int v,
                        input int s, input int w, input int e, input int l, input int ec);
        vec_t t;
        t.rr = rr; t.cc = cc; t.g = g; t.b = b; t.v = v; t.s = s;
        t.w = w; t.e = e; t.l = l; t.ec = ec;
        vecs.push_back(t);
    endtask

    initial begin
        int nb, pick;
        vec_t t;
        r = 1'b1; ce = 1'b0; G = '0;

        // Reset wins over a simultaneous sample
        addv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        // Full Gray sequence: reference, then legal steps, lock after third sample
        addv(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        addv(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        addv(0, 1, 3, 2, 1, 1, 0, 0, 1, 0);
        for (int k = 3; k < MODN; k++)
            addv(0, 1, k ^ (k >> 1), k, 1, 1, 0, 0, 1, 0);
        // Wrap 15 -> 0 while locked
        addv(0, 1, 0, 0, 1, 1, 1, 0, 1, 0);
        addv(0, 1, 1, 1, 1, 1, 0, 0, 1, 0);
        addv(0, 1, 3, 2, 1, 1, 0, 0, 1, 0);
        // Skip 2 -> 4: error drops lock; relock after two good steps
        addv(0, 1, 6, 4, 1, 0, 0, 1, 0, 1);
        addv(0, 1, 7, 5, 1, 1, 0, 0, 0, 1);
        addv(0, 1, 5, 6, 1, 1, 0, 0, 1, 1);
        // Backwards step is an error; then stall on G=0010 (B=3)
        addv(0, 1, 2, 3, 1, 0, 0, 1, 0, 2);
        addv(0, 1, 2, 3, 1, 0, 0, 0, 0, 2);
        addv(0, 1, 2, 3, 1, 0, 0, 0, 0, 2);
        // ce low: everything holds, pulses clear
        addv(0, 0, 15, 3, 0, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 3, 0, 0, 0, 0, 0, 2);
        // Three more illegal steps: counter saturates at 3
        addv(0, 1, 0, 0, 1, 0, 0, 1, 0, 3);
        addv(0, 1, 15, 10, 1, 0, 0, 1, 0, 3);
        addv(0, 1, 1, 1, 1, 0, 0, 1, 0, 3);
        addv(0, 1, 3, 2, 1, 1, 0, 0, 0, 3);
        addv(0, 1, 2, 3, 1, 1, 0, 0, 1, 3);
        // Reset with ce while locked; next sample is a reference only
        addv(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 1, 15, 10, 1, 0, 0, 0, 0, 0);
        addv(0, 1, 14, 11, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            drive(t.rr, t.cc, t.g);
            chk($sformatf("v%0d.B", i),       int'(B),       t.b);
            chk($sformatf("v%0d.valid", i),   int'(valid),   t.v);
            chk($sformatf("v%0d.step_ok", i), int'(step_ok), t.s);
            chk($sformatf("v%0d.wrap", i),    int'(wrap),    t.w);
            chk($sformatf("v%0d.err", i),     int'(err),     t.e);
            chk($sformatf("v%0d.locked", i),  int'(locked),  t.l);
            chk($sformatf("v%0d.err_cnt", i), int'(err_cnt), (EC_CAP == 0) ? 0 : t.ec);
        end

        // Randomized traffic checked against the model
        for (int n = 0; n < 800; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 6)      nb = (m_prev + 1) % MODN;
            else if (pick < 8) nb = m_prev;
            else               nb = int'($urandom_range(0, MODN - 1));
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), nb ^ (nb >> 1));
            chk($sformatf("r%0d.B", n),       int'(B),       m_b);
            chk($sformatf("r%0d.valid", n),   int'(valid),   m_v);
            chk($sformatf("r%0d.step_ok", n), int'(step_ok), m_s);
            chk($sformatf("r%0d.wrap", n),    int'(wrap),    m_w);
            chk($sformatf("r%0d.err", n),     int'(err),     m_e);
            chk($sformatf("r%0d.locked", n),  int'(locked),  m_lk);
            chk($sformatf("r%0d.err_cnt", n), int'(err_cnt), m_ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
